// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI4 channel types and helpers used by the burst address sequencer
// and its command legality checker.
package PKG_axi;

  typedef enum logic [2:0] {
    AXI_SIZE_1   = 3'd0,
    AXI_SIZE_2   = 3'd1,
    AXI_SIZE_4   = 3'd2,
    AXI_SIZE_8   = 3'd3,
    AXI_SIZE_16  = 3'd4,
    AXI_SIZE_32  = 3'd5,
    AXI_SIZE_64  = 3'd6,
    AXI_SIZE_128 = 3'd7
  } axi_axsize_e;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2,
    AXI_BURST_RSVD  = 2'd3
  } axi_axburst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'd0,
    AXI_RESP_EXOKAY = 2'd1,
    AXI_RESP_SLVERR = 2'd2,
    AXI_RESP_DECERR = 2'd3
  } axi_rwresp_e;

  typedef enum logic {
    AXI_LOCK_NORMAL    = 1'b0,
    AXI_LOCK_EXCLUSIVE = 1'b1
  } axi_axlock_e;

  localparam int unsigned AXI_4K_BITS      = 12;
  localparam int unsigned AXI_WRAP_MAX_LEN = 15;

  function automatic int unsigned axi_size_bytes(axi_axsize_e size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi_burst_cmd_check.sv
// Combinational AXI4 command legality check plus the burst geometry
// (beat size, wrap window bounds) needed to walk the beats.
module axi_burst_cmd_check
  import PKG_axi::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 64,
  parameter int unsigned LEN_W    = 8,
  parameter bit          CHECK_4K = 1'b1
) (
  input  logic [AW-1:0]    addr,
  input  logic [LEN_W-1:0] len,
  input  logic [2:0]       size,
  input  logic [1:0]       burst,
  output logic             illegal,
  output logic [AW-1:0]    bytes,
  output logic [AW-1:0]    lower,
  output logic [AW-1:0]    upper
);

  localparam int unsigned OFF_W = $clog2(DW / 8);

  logic [AW-1:0] beats;
  logic [AW-1:0] total;
  logic [AW-1:0] aligned;
  logic [AW-1:0] lastByte;
  logic          wrapLenOk;
  logic          isFixed;
  logic          isIncr;
  logic          isWrap;

  always_comb begin
    bytes    = AW'(axi_size_bytes(axi_axsize_e'(size)));
    beats    = AW'(len) + AW'(1);
    total    = bytes * beats;
    aligned  = addr & ~(bytes - AW'(1));
    lower    = addr & ~(total - AW'(1));
    upper    = lower + total;
    lastByte = aligned + total - AW'(1);

    isFixed  = (burst == AXI_BURST_FIXED);
    isIncr   = (burst == AXI_BURST_INCR);
    isWrap   = (burst == AXI_BURST_WRAP);
    // len+1 must be a power of two between 2 and 16 beats
    wrapLenOk = (len != '0) && ((len & (len + LEN_W'(1))) == '0)
                && (32'(len) <= AXI_WRAP_MAX_LEN);

    illegal = 1'b0;
    if (burst == AXI_BURST_RSVD) illegal = 1'b1;
    if (32'(size) > OFF_W) illegal = 1'b1;
    if ((isFixed || isWrap) && (32'(len) > AXI_WRAP_MAX_LEN)) illegal = 1'b1;
    if (isWrap && !wrapLenOk) illegal = 1'b1;
    if (isWrap && ((addr & (bytes - AW'(1))) != '0)) illegal = 1'b1;
    if (CHECK_4K && isIncr
        && (lastByte[AW-1:AXI_4K_BITS] != addr[AW-1:AXI_4K_BITS])) illegal = 1'b1;
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI4 AR/AW command into per-beat address, lane, index, last
// and response descriptors, one beat per cycle with zero-bubble chaining.
module axi_burst_addr_gen
  import PKG_axi::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 64,
  parameter int unsigned LEN_W    = 8,
  parameter bit          CHECK_4K = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [AW-1:0]                           cmd_addr,
  input  logic [LEN_W-1:0]                        cmd_len,
  input  logic [2:0]                              cmd_size,
  input  logic [1:0]                              cmd_burst,
  output logic                                    beat_valid,
  input  logic                                    beat_ready,
  output logic [AW-1:0]                           beat_addr,
  output logic [((DW > 8) ? $clog2(DW/8) : 1)-1:0] beat_lane,
  output logic [LEN_W-1:0]                        beat_idx,
  output logic                                    beat_last,
  output logic [1:0]                              beat_resp,
  output logic                                    busy
);

  localparam int unsigned OFF_W  = $clog2(DW / 8);
  localparam int unsigned LANE_W = (DW > 8) ? OFF_W : 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state,  stateD;
  logic [AW-1:0] addrQ,  addrD;
  logic [LEN_W-1:0] idxQ, idxD;
  logic [LEN_W-1:0] lenQ, lenD;
  logic          lastQ,  lastD;
  axi_rwresp_e   respQ,  respD;
  logic [AW-1:0] bytesQ, bytesD;
  logic [AW-1:0] lowerQ, lowerD;
  logic [AW-1:0] upperQ, upperD;
  logic          holdQ,  holdD;
  logic          wrapQ,  wrapD;

  logic          chkIllegal;
  logic [AW-1:0] chkBytes;
  logic [AW-1:0] chkLower;
  logic [AW-1:0] chkUpper;
  logic [AW-1:0] stepAddr;
  logic          beatHs;
  logic          cmdAcc;

  axi_burst_cmd_check #(
    .AW       (AW),
    .DW       (DW),
    .LEN_W    (LEN_W),
    .CHECK_4K (CHECK_4K)
  ) uCheck (
    .addr    (cmd_addr),
    .len     (cmd_len),
    .size    (cmd_size),
    .burst   (cmd_burst),
    .illegal (chkIllegal),
    .bytes   (chkBytes),
    .lower   (chkLower),
    .upper   (chkUpper)
  );

  assign beat_valid = (state == BURST);
  assign busy       = (state == BURST);
  assign beatHs     = beat_valid & beat_ready;
  assign cmd_ready  = (state == IDLE) | (beatHs & lastQ);
  assign cmdAcc     = cmd_valid & cmd_ready;

  assign beat_addr = addrQ;
  assign beat_idx  = idxQ;
  assign beat_last = lastQ;
  assign beat_resp = respQ;

  generate
    if (OFF_W == 0) begin : gNoLane
      assign beat_lane = '0;
    end else begin : gLane
      assign beat_lane = addrQ[LANE_W-1:0];
    end
  endgenerate

  always_comb begin
    stateD = state;
    addrD  = addrQ;
    idxD   = idxQ;
    lenD   = lenQ;
    lastD  = lastQ;
    respD  = respQ;
    bytesD = bytesQ;
    lowerD = lowerQ;
    upperD = upperQ;
    holdD  = holdQ;
    wrapD  = wrapQ;

    // Re-aligning every step lets an unaligned INCR start share the same path
    stepAddr = (addrQ & ~(bytesQ - AW'(1))) + bytesQ;
    if (wrapQ && (stepAddr == upperQ)) stepAddr = lowerQ;

    case (state)
      IDLE: ;
      BURST: begin
        if (beatHs) begin
          if (lastQ) begin
            stateD = IDLE;
            lastD  = 1'b0;
          end else begin
            idxD  = idxQ + LEN_W'(1);
            lastD = ((idxQ + LEN_W'(1)) == lenQ);
            addrD = holdQ ? addrQ : stepAddr;
          end
        end
      end
      default: stateD = IDLE;
    endcase

    // A command accepted on the final handshake chains straight into BURST
    if (cmdAcc) begin
      stateD = BURST;
      addrD  = cmd_addr;
      idxD   = '0;
      lenD   = cmd_len;
      lastD  = (cmd_len == '0);
      respD  = chkIllegal ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      bytesD = chkBytes;
      lowerD = chkLower;
      upperD = chkUpper;
      holdD  = chkIllegal | (cmd_burst == AXI_BURST_FIXED);
      wrapD  = (cmd_burst == AXI_BURST_WRAP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addrQ  <= '0;
      idxQ   <= '0;
      lenQ   <= '0;
      lastQ  <= 1'b0;
      respQ  <= AXI_RESP_OKAY;
      bytesQ <= '0;
      lowerQ <= '0;
      upperQ <= '0;
      holdQ  <= 1'b0;
      wrapQ  <= 1'b0;
    end else begin
      state  <= stateD;
      addrQ  <= addrD;
      idxQ   <= idxD;
      lenQ   <= lenD;
      lastQ  <= lastD;
      respQ  <= respD;
      bytesQ <= bytesD;
      lowerQ <= lowerD;
      upperQ <= upperD;
      holdQ  <= holdD;
      wrapQ  <= wrapD;
    end
  end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Bench for axi_burst_addr_gen: directed vector table, multi-cycle corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_axi_burst_addr_gen;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned NCMD  = 150;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [2:0]    cmd_size = '0;
  logic [1:0]    cmd_burst = '0;
  logic          beat_valid;
  logic          beat_ready = 1'b0;
  logic [31:0]   beat_addr;
  logic [2:0]    beat_lane;
  logic [7:0]    beat_idx;
  logic          beat_last;
  logic [1:0]    beat_resp;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  axi_burst_addr_gen #(
    .AW       (AW),
    .DW       (DW),
    .LEN_W    (LEN_W),
    .CHECK_4K (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_lane  (beat_lane),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .beat_resp  (beat_resp),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: closed-form beat address from the AXI rules.
  function automatic bit modelIllegal(logic [31:0] a, logic [7:0] len, logic [2:0] size,
                                      logic [1:0] burst);
    longint unsigned bytes, total, al, endB;
    bytes = 64'd1 << size;
    total = bytes * (64'(len) + 64'd1);
    al    = 64'(a) - (64'(a) % bytes);
    endB  = (al + total - 64'd1) & 64'hFFFF_FFFF;
    if (burst == 2'd3) return 1'b1;
    if (bytes > 64'd8) return 1'b1;
    if (burst != 2'd1 && len > 8'd15) return 1'b1;
    if (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) return 1'b1;
    if (burst == 2'd2 && (64'(a) % bytes) != 64'd0) return 1'b1;
    if (burst == 2'd1 && (endB >> 12) != (64'(a) >> 12)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelAddr(logic [31:0] a, logic [7:0] len, logic [2:0] size,
                                            logic [1:0] burst, int unsigned i);
    longint unsigned bytes, total, al, lo;
    bytes = 64'd1 << size;
    total = bytes * (64'(len) + 64'd1);
    al    = 64'(a) - (64'(a) % bytes);
    if (modelIllegal(a, len, size, burst) || burst == 2'd0) return a;
    if (burst == 2'd1) return (i == 0) ? a : 32'(al + 64'(i) * bytes);
    lo = 64'(a) - (64'(a) % total);
    return 32'(lo + ((64'(a) - lo + 64'(i) * bytes) % total));
  endfunction

  typedef struct packed {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [2:0]       nBeats;
    logic [3:0][31:0] expAddr;
    logic [1:0]       expResp;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  idx;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

  vec_t  vecs[8];
  beat_t expQ[$];

  task automatic sendCmd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input string tag);
    int w;
    @(negedge clk);
    cmd_addr = a; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1; beat_ready = 1'b1;
    #1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    chk({tag, "_accept"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic runVec(input vec_t v, input string tag);
    sendCmd(v.addr, v.len, v.size, v.burst, tag);
    for (int unsigned i = 0; i < v.nBeats; i++) begin
      #1;
      chk($sformatf("%s_b%0d_valid", tag, i), beat_valid, 1);
      chk($sformatf("%s_b%0d_addr", tag, i), beat_addr, v.expAddr[i]);
      chk($sformatf("%s_b%0d_lane", tag, i), beat_lane, v.expAddr[i] & 32'h7);
      chk($sformatf("%s_b%0d_idx", tag, i), beat_idx, i);
      chk($sformatf("%s_b%0d_last", tag, i), beat_last, (i == v.nBeats - 1));
      chk($sformatf("%s_b%0d_resp", tag, i), beat_resp, v.expResp);
      @(negedge clk);
    end
    #1;
    chk({tag, "_end_valid"}, beat_valid, 0);
    chk({tag, "_end_ready"}, cmd_ready, 1);
  endtask

  task automatic genCmd();
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    size  = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
    burst = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    a     = $urandom;
    if ($urandom_range(0, 1) == 1) a[11:0] = 12'($urandom_range(0, 255));
    case (burst)
      2'd1:    len = ($urandom_range(0, 20) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
      2'd2: begin
        len = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 20))
                                           : 8'((2 << $urandom_range(0, 3)) - 1);
        if ($urandom_range(0, 3) != 0) a[3:0] = 4'd0;
      end
      default: len = 8'($urandom_range(0, 18));
    endcase
    cmd_addr = a; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1;
  endtask

  initial begin
    bit          acc;
    bit          expReady;
    int          sent;
    int          b2b;
    beat_t       e;

    // addr, len, size, burst, nBeats, {b3,b2,b1,b0}, resp
    vecs[0] = '{32'h1004, 8'd3, 3'd2, 2'd1, 3'd4, {32'h1010, 32'h100C, 32'h1008, 32'h1004}, 2'd0};
    vecs[1] = '{32'h1038, 8'd3, 3'd2, 2'd2, 3'd4, {32'h1034, 32'h1030, 32'h103C, 32'h1038}, 2'd0};
    vecs[2] = '{32'h2000, 8'd2, 3'd3, 2'd0, 3'd3, {32'h0,    32'h2000, 32'h2000, 32'h2000}, 2'd0};
    vecs[3] = '{32'h0100, 8'd2, 3'd2, 2'd2, 3'd3, {32'h0,    32'h0100, 32'h0100, 32'h0100}, 2'd2};
    vecs[4] = '{32'h0FF8, 8'd3, 3'd3, 2'd1, 3'd4, {32'h0FF8, 32'h0FF8, 32'h0FF8, 32'h0FF8}, 2'd2};
    vecs[5] = '{32'h0080, 8'd0, 3'd4, 2'd1, 3'd1, {32'h0,    32'h0,    32'h0,    32'h0080}, 2'd2};
    vecs[6] = '{32'h0FF0, 8'd1, 3'd3, 2'd1, 3'd2, {32'h0,    32'h0,    32'h0FF8, 32'h0FF0}, 2'd0};
    vecs[7] = '{32'h0040, 8'd0, 3'd3, 2'd1, 3'd1, {32'h0,    32'h0,    32'h0,    32'h0040}, 2'd0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_valid", beat_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", beat_last, 0);
    chk("rst_addr", beat_addr, 0);
    chk("rst_idx", beat_idx, 0);
    chk("rst_lane", beat_lane, 0);
    chk("rst_resp", beat_resp, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    for (int unsigned n = 0; n < 7; n++) runVec(vecs[n], $sformatf("vec%0d", n));

    // Full-length INCR: index must reach 255 with last only there
    sendCmd(32'h3000, 8'd255, 3'd0, 2'd1, "full");
    for (int unsigned i = 0; i < 256; i++) begin
      #1;
      chk("full_addr", beat_addr, 32'h3000 + i);
      chk("full_idx", beat_idx, i);
      chk("full_last", beat_last, (i == 255));
      @(negedge clk);
    end
    #1;
    chk("full_end_valid", beat_valid, 0);

    // Reset landing on beat 2 of an 8-beat INCR
    sendCmd(32'h0, 8'd7, 3'd3, 2'd1, "rstmid");
    @(negedge clk);
    @(negedge clk); #1;
    chk("rstmid_idx2", beat_idx, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rstmid_valid", beat_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_idx", beat_idx, 0);
    runVec(vecs[7], "after_rst");

    // Randomized traffic with stalls and back-to-back commands
    acc = 1'b0; sent = 0; b2b = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (acc) begin cmd_valid = 1'b0; acc = 1'b0; end
      if (sent == NCMD && expQ.size() == 0 && !cmd_valid) break;
      beat_ready = ($urandom_range(0, 3) != 0);
      if (!cmd_valid && sent < NCMD && $urandom_range(0, 2) != 0) genCmd();
      #1;
      expReady = (expQ.size() == 0) || (beat_ready && expQ[0].last);
      chk("rnd_cmd_ready", cmd_ready, expReady);
      chk("rnd_valid", beat_valid, expQ.size() != 0);
      chk("rnd_busy", busy, expQ.size() != 0);
      if (beat_valid && expQ.size() != 0) begin
        e = expQ[0];
        chk("rnd_addr", beat_addr, e.addr);
        chk("rnd_lane", beat_lane, e.addr & 32'h7);
        chk("rnd_idx", beat_idx, e.idx);
        chk("rnd_last", beat_last, e.last);
        chk("rnd_resp", beat_resp, e.resp);
        if (beat_ready) begin
          if (e.last && cmd_valid && cmd_ready) b2b++;
          void'(expQ.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) begin
        for (int unsigned i = 0; i <= cmd_len; i++)
          expQ.push_back('{modelAddr(cmd_addr, cmd_len, cmd_size, cmd_burst, i), 8'(i),
                           (i == cmd_len),
                           modelIllegal(cmd_addr, cmd_len, cmd_size, cmd_burst) ? 2'd2 : 2'd0});
        sent++;
        acc = 1'b1;
      end
    end
    chk("rnd_drained", (sent == NCMD) && (expQ.size() == 0), 1);
    chk("rnd_b2b_seen", b2b > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
